// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared ALUOp codes, function codes and control-word layout.
// Revision: 1.0  initial release
// ============================================================================
package alu_pkg;

  // Operation classes driven by the main control unit
  localparam logic [2:0] ALUOP_NONE    = 3'b000;
  localparam logic [2:0] ALUOP_ARITH   = 3'b001;
  localparam logic [2:0] ALUOP_SHIFTC  = 3'b010;
  localparam logic [2:0] ALUOP_SHIFTV  = 3'b011;
  localparam logic [2:0] ALUOP_IMM     = 3'b100;
  localparam logic [2:0] ALUOP_COMPI   = 3'b101;
  localparam logic [2:0] ALUOP_BRANCH  = 3'b110;

  localparam int unsigned FC_W = 10;

  localparam logic [FC_W-1:0] FC_ADD  = 10'd0;
  localparam logic [FC_W-1:0] FC_AND  = 10'd1;
  localparam logic [FC_W-1:0] FC_XOR  = 10'd2;
  localparam logic [FC_W-1:0] FC_COMP = 10'd3;
  localparam logic [FC_W-1:0] FC_SHL  = 10'd0;
  localparam logic [FC_W-1:0] FC_SHRL = 10'd1;
  localparam logic [FC_W-1:0] FC_SHRA = 10'd2;

  localparam logic [2:0] FUNC_ADD   = 3'b000;
  localparam logic [2:0] FUNC_AND   = 3'b001;
  localparam logic [2:0] FUNC_XOR   = 3'b010;
  localparam logic [2:0] FUNC_COMP  = 3'b011;
  localparam logic [2:0] FUNC_SHIFT = 3'b100;
  localparam logic [2:0] FUNC_PASSA = 3'b101;

  localparam logic [1:0] SHIFT_NONE = 2'b00;
  localparam logic [1:0] SHIFT_LL   = 2'b01;
  localparam logic [1:0] SHIFT_RL   = 2'b10;
  localparam logic [1:0] SHIFT_RA   = 2'b11;

  localparam logic B_RT  = 1'b0;
  localparam logic B_IMM = 1'b1;

  localparam int unsigned CTRL_W = 7;

  typedef struct packed {
    logic       valid;
    logic       b_src;
    logic [1:0] shift;
    logic [2:0] func;
  } ctrl_word_t;

  function automatic ctrl_word_t make_ctrl(input logic       b_src,
                                           input logic [1:0] shift,
                                           input logic [2:0] func);
    ctrl_word_t w;
    w.valid = 1'b1;
    w.b_src = b_src;
    w.shift = shift;
    w.func  = func;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_control_decode.sv
`default_nettype none
// ============================================================================
// Module  : alu_control_decode
// Brief   : Combinational ALUOp/function-code to ALU control-word decoder.
// Revision: 1.0  initial release
// ============================================================================
module alu_control_decode
  import alu_pkg::*;
(
  input  logic [2:0]        ALUOp,
  input  logic [FC_W-1:0]   function_code,
  output logic [CTRL_W-1:0] w_ctrl,
  output logic              w_illegal
);

  ctrl_word_t w_word;

  always_comb begin
    w_word    = '0;
    w_illegal = 1'b0;
    unique case (ALUOp)
      ALUOP_NONE: ;
      ALUOP_ARITH: begin
        unique case (function_code)
          FC_ADD:  w_word = make_ctrl(B_RT, SHIFT_NONE, FUNC_ADD);
          FC_AND:  w_word = make_ctrl(B_RT, SHIFT_NONE, FUNC_AND);
          FC_XOR:  w_word = make_ctrl(B_RT, SHIFT_NONE, FUNC_XOR);
          FC_COMP: w_word = make_ctrl(B_RT, SHIFT_NONE, FUNC_COMP);
          default: w_illegal = 1'b1;
        endcase
      end
      // Constant shifts take the amount from shamt, hence the immediate B-source
      ALUOP_SHIFTC: begin
        unique case (function_code)
          FC_SHL:  w_word = make_ctrl(B_IMM, SHIFT_LL, FUNC_SHIFT);
          FC_SHRL: w_word = make_ctrl(B_IMM, SHIFT_RL, FUNC_SHIFT);
          FC_SHRA: w_word = make_ctrl(B_IMM, SHIFT_RA, FUNC_SHIFT);
          default: w_illegal = 1'b1;
        endcase
      end
      ALUOP_SHIFTV: begin
        unique case (function_code)
          FC_SHL:  w_word = make_ctrl(B_RT, SHIFT_LL, FUNC_SHIFT);
          FC_SHRL: w_word = make_ctrl(B_RT, SHIFT_RL, FUNC_SHIFT);
          FC_SHRA: w_word = make_ctrl(B_RT, SHIFT_RA, FUNC_SHIFT);
          default: w_illegal = 1'b1;
        endcase
      end
      ALUOP_IMM:    w_word = make_ctrl(B_IMM, SHIFT_NONE, FUNC_ADD);
      ALUOP_COMPI:  w_word = make_ctrl(B_IMM, SHIFT_NONE, FUNC_COMP);
      ALUOP_BRANCH: w_word = make_ctrl(B_RT,  SHIFT_NONE, FUNC_PASSA);
      default:      w_illegal = 1'b1;
    endcase
  end

  assign w_ctrl = w_word;

endmodule
`default_nettype wire

// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
// Module  : alu_control
// Brief   : Registered ALU control decode with undefined-combination flag.
// Revision: 1.0  initial release
// ============================================================================
module alu_control
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ALUOp,
  input  logic [FC_W-1:0]   function_code,
  output logic [CTRL_W-1:0] control_signal,
  output logic              illegal
);

  logic [CTRL_W-1:0] w_ctrl;
  logic              w_illegal;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_illegal;

  alu_control_decode u_decode (
    .ALUOp         (ALUOp),
    .function_code (function_code),
    .w_ctrl        (w_ctrl),
    .w_illegal     (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl;
      r_illegal <= w_illegal;
    end
  end

  assign control_signal = r_ctrl;
  assign illegal        = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_control
// Brief   : Self-checking bench for alu_control against a table-driven model.
// Revision: 1.0  initial release
// ============================================================================
module tb_alu_control;

  logic       clk;
  logic       rst_n;
  logic [2:0] ALUOp;
  logic [9:0] function_code;
  logic [6:0] control_signal;
  logic       illegal;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] ARITH_TBL  [0:3] = '{7'b1000000, 7'b1000001, 7'b1000010, 7'b1000011};
  localparam logic [6:0] SHIFTC_TBL [0:2] = '{7'b1101100, 7'b1110100, 7'b1111100};
  localparam logic [6:0] SHIFTV_TBL [0:2] = '{7'b1001100, 7'b1010100, 7'b1011100};

  alu_control dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ALUOp          (ALUOp),
    .function_code  (function_code),
    .control_signal (control_signal),
    .illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {illegal, control word} for one input pair
  function automatic logic [7:0] ref_decode(input logic [2:0] op, input logic [9:0] fc);
    int f;
    f = int'(fc);
    case (op)
      3'd0: return 8'h00;
      3'd1: return (f < 4) ? {1'b0, ARITH_TBL[f]}  : 8'h80;
      3'd2: return (f < 3) ? {1'b0, SHIFTC_TBL[f]} : 8'h80;
      3'd3: return (f < 3) ? {1'b0, SHIFTV_TBL[f]} : 8'h80;
      3'd4: return {1'b0, 7'b1100000};
      3'd5: return {1'b0, 7'b1100011};
      3'd6: return {1'b0, 7'b1000101};
      default: return 8'h80;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs at the falling edge, then check the register one edge later
  task automatic step(input string tag, input logic rn, input logic [2:0] op, input logic [9:0] fc);
    logic [7:0] exp;
    @(negedge clk);
    rst_n         = rn;
    ALUOp         = op;
    function_code = fc;
    exp = rn ? ref_decode(op, fc) : 8'h00;
    @(posedge clk);
    #1;
    // Inputs moving after the edge must not disturb the registered result
    ALUOp         = 3'd7;
    function_code = 10'h155;
    #1;
    chk({tag, ".ctrl"},    {1'b0, control_signal}, {1'b0, exp[6:0]});
    chk({tag, ".illegal"}, {7'b0, illegal},        {7'b0, exp[7]});
  endtask

  initial begin
    rst_n         = 1'b0;
    ALUOp         = 3'd1;
    function_code = 10'd0;

    step("reset0", 1'b0, 3'd1, 10'd0);
    step("reset1", 1'b0, 3'd1, 10'd0);

    for (int i = 0; i < 4; i++) step("arith",  1'b1, 3'd1, 10'(i));
    for (int i = 0; i < 3; i++) step("shiftc", 1'b1, 3'd2, 10'(i));
    for (int i = 0; i < 3; i++) step("shiftv", 1'b1, 3'd3, 10'(i));

    step("imm",      1'b1, 3'd4, 10'h3FF);
    step("compi",    1'b1, 3'd5, 10'h3FF);
    step("branch",   1'b1, 3'd6, 10'h3FF);
    step("op7",      1'b1, 3'd7, 10'd0);
    step("shc_fc3",  1'b1, 3'd2, 10'd3);
    step("shv_fc3",  1'b1, 3'd3, 10'd3);
    step("ar_fc200", 1'b1, 3'd1, 10'h200);
    step("ar_fc4",   1'b1, 3'd1, 10'd4);
    step("none",     1'b1, 3'd0, 10'h3FF);

    step("midrst",   1'b0, 3'd5, 10'd7);
    step("release",  1'b1, 3'd5, 10'd7);

    for (int i = 0; i < 200; i++) begin
      logic [2:0] op;
      logic [9:0] fc;
      logic       rn;
      op = 3'($urandom_range(0, 7));
      fc = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 4));
      rn = ($urandom_range(0, 15) != 0);
      step("rand", rn, op, fc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
